// File: rtl/bits_pack.sv
// Packs 1..15-bit fields LSB-first into 32-bit words and queues them in a small output FIFO.
// Latency: word-completing push -> pushout two edges later; stopout reserves two free FIFO slots.
module bits_pack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pushin,
   input  logic [3:0]  lenin,
   input  logic [14:0] datain,
   input  logic        flushin,
   output logic        stopout,
   output logic        pushout,
   output logic [31:0] dataout,
   input  logic        stopin
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [46:0]   acc_q, acc_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, wr_nxt;
   logic [CW-1:0] count_q, count_d;
   logic          pushout_q;
   logic [31:0]   dataout_q;
   logic [31:0]   mem [DEPTH];

   logic          accept, push_ok, full_wr, flush_wr, pop;
   logic [14:0]   fmask;
   logic [46:0]   ins, acc_a, acc_b;
   logic [5:0]    sum_a;
   logic [4:0]    cnt_b;
   logic          wa_vld, wb_vld;
   logic [31:0]   wa_dat, wb_dat;
   logic [1:0]    n_wr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign stopout = (count_q >= CW'(DEPTH - 2));
   assign pushout = pushout_q;
   assign dataout = dataout_q;

   always_comb begin
      accept   = !stopout;
      push_ok  = pushin && accept && (lenin != 4'd0);
      fmask    = 15'h7FFF >> (4'd15 - lenin);
      ins      = {32'd0, datain & fmask} << cnt_q;
      acc_a    = push_ok ? (acc_q | ins) : acc_q;
      sum_a    = push_ok ? ({1'b0, cnt_q} + {2'b00, lenin}) : {1'b0, cnt_q};
      // sum never reaches 64, so bit 5 alone marks a completed word
      full_wr  = sum_a[5];
      acc_b    = full_wr ? (acc_a >> 32) : acc_a;
      cnt_b    = sum_a[4:0];
      flush_wr = flushin && accept && (cnt_b != 5'd0);
      acc_d    = flush_wr ? '0 : acc_b;
      cnt_d    = flush_wr ? 5'd0 : cnt_b;

      // Up to two writes per cycle: the completed word first, then the padded remainder
      wa_vld   = full_wr || flush_wr;
      wa_dat   = full_wr ? acc_a[31:0] : acc_b[31:0];
      wb_vld   = full_wr && flush_wr;
      wb_dat   = acc_b[31:0];
      n_wr     = {1'b0, wa_vld} + {1'b0, wb_vld};

      wr_nxt   = ptr_inc(wr_q);
      if (n_wr == 2'd2)
         wr_d = ptr_inc(wr_nxt);
      else if (n_wr == 2'd1)
         wr_d = wr_nxt;
      else
         wr_d = wr_q;

      pop      = (count_q != '0) && !stopin;
      rd_d     = pop ? ptr_inc(rd_q) : rd_q;
      count_d  = count_q + CW'(n_wr) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
         pushout_q <= 1'b0;
         dataout_q <= '0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         count_q   <= count_d;
         pushout_q <= pop;
         if (pop)
            dataout_q <= mem[rd_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wa_vld)
         mem[wr_q] <= wa_dat;
      if (!rst && wb_vld)
         mem[wr_nxt] <= wb_dat;
   end

endmodule

// File: tb/tb_bits_pack.sv
// Table-driven bench for bits_pack with a word scoreboard checked on every pushout.
module tb_bits_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        pushin;
   logic [3:0]  lenin;
   logic [14:0] datain;
   logic        flushin;
   logic        stopout;
   logic        pushout;
   logic [31:0] dataout;
   logic        stopin;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit rand_mode = 1'b0;
   logic [31:0] sb[$];

   typedef struct {
      logic        p;
      logic [3:0]  len;
      logic [14:0] dat;
      logic        f;
      int          nexp;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vt[$];

   bits_pack #(.DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .pushin  (pushin),
      .lenin   (lenin),
      .datain  (datain),
      .flushin (flushin),
      .stopout (stopout),
      .pushout (pushout),
      .dataout (dataout),
      .stopin  (stopin)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Scoreboard compare of every emitted word
   always @(negedge clk) begin
      if (rst === 1'b0 && pushout === 1'b1) begin
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_word: got %h, expected no word", dataout);
         end else begin
            chk("word", dataout, sb.pop_front());
         end
      end
   end

   function automatic void add_v(input logic p, input logic [3:0] len, input logic [14:0] dat,
                                 input logic f, input int nexp, input logic [31:0] e0,
                                 input logic [31:0] e1);
      vec_t v;
      v.p = p; v.len = len; v.dat = dat; v.f = f; v.nexp = nexp; v.e0 = e0; v.e1 = e1;
      vt.push_back(v);
   endfunction

   task automatic idle_cycle();
      pushin  = 1'b0;
      flushin = 1'b0;
      if (rand_mode)
         stopin = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic [3:0] len, input logic [14:0] dat,
                        input logic f, input int nexp, input logic [31:0] e0,
                        input logic [31:0] e1);
      int guard = 0;
      while (stopout && guard < 500) begin
         idle_cycle();
         guard++;
      end
      if (guard >= 500) begin
         total_cnt++;
         $display("FAIL stopout_stuck: got stopout=1, expected 0 within 500 cycles");
      end
      if (rand_mode)
         stopin = 1'($urandom_range(0, 1));
      pushin  = p;
      lenin   = len;
      datain  = dat;
      flushin = f;
      if (nexp >= 1) sb.push_back(e0);
      if (nexp >= 2) sb.push_back(e1);
      @(posedge clk);
      #1;
      pushin  = 1'b0;
      flushin = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         idle_cycle();
         guard++;
      end
      stopin = 1'b0;
      repeat (3) idle_cycle();
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; pushin = 1'b0; lenin = '0; datain = '0; flushin = 1'b0; stopin = 1'b0;

      // Table: nibble word, 15-bit straddle, push+flush double write, no-ops, masking, mixed lengths
      for (int i = 1; i <= 8; i++)
         add_v(1'b1, 4'd4, 15'(i), 1'b0, (i == 8) ? 1 : 0, 32'h87654321, 32'h0);
      add_v(1'b1, 4'd15, 15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd15, 15'h0000, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd15, 15'h5555, 1'b0, 1, 32'h40007FFF, 32'h0);
      add_v(1'b0, 4'd0,  15'h0000, 1'b1, 1, 32'h00001555, 32'h0);
      add_v(1'b1, 4'd15, 15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd15, 15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd4,  15'h000A, 1'b1, 2, 32'hBFFFFFFF, 32'h00000002);
      add_v(1'b1, 4'd0,  15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b0, 4'd0,  15'h0000, 1'b1, 0, 32'h0, 32'h0);
      for (int i = 8; i >= 1; i--)
         add_v(1'b1, 4'd4, 15'h7FF0 | 15'(i), 1'b0, (i == 1) ? 1 : 0, 32'h12345678, 32'h0);
      add_v(1'b0, 4'd0,  15'h0000, 1'b1, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd0,  15'h7FFF, 1'b1, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd1,  15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd3,  15'h0005, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd15, 15'h7FFE, 1'b0, 0, 32'h0, 32'h0);
      add_v(1'b1, 4'd13, 15'h1ABC, 1'b0, 1, 32'hD5E7FFEB, 32'h0);
      add_v(1'b1, 4'd2,  15'h0003, 1'b1, 1, 32'h00000003, 32'h0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_pushout", 32'(pushout), 32'd0);
      chk("reset_dataout", dataout, 32'd0);
      chk("reset_stopout", 32'(stopout), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycle();

      // First-word latency: pushout exactly two edges after the completing push
      for (int i = 1; i <= 8; i++) begin
         pushin = 1'b1; lenin = 4'd4; datain = 15'(i);
         if (i == 8) sb.push_back(32'h87654321);
         @(posedge clk);
         #1;
      end
      pushin = 1'b0;
      @(negedge clk);
      chk("latency_early", 32'(pushout), 32'd0);
      @(negedge clk);
      chk("latency_on_time", 32'(pushout), 32'd1);
      wait_drain("drain_latency");

      for (int pass = 0; pass < 2; pass++) begin
         rand_mode = (pass == 1);
         for (int i = 0; i < vt.size(); i++)
            drive(vt[i].p, vt[i].len, vt[i].dat, vt[i].f, vt[i].nexp, vt[i].e0, vt[i].e1);
         wait_drain(pass == 0 ? "drain_table" : "drain_table_random_stop");
      end
      rand_mode = 1'b0;

      // Backpressure fill to stopout, ignored illegal push, back-to-back drain
      stopin = 1'b1;
      drive(1'b1, 4'd4, 15'h1, 1'b1, 1, 32'h1, 32'h0);
      chk("bp_stopout_count1", 32'(stopout), 32'd0);
      drive(1'b1, 4'd4, 15'h2, 1'b1, 1, 32'h2, 32'h0);
      chk("bp_stopout_count2", 32'(stopout), 32'd1);
      pushin = 1'b1; lenin = 4'd15; datain = 15'h7FFF; flushin = 1'b1;
      @(posedge clk);
      #1;
      pushin = 1'b0; flushin = 1'b0;
      chk("bp_ignored_stopout", 32'(stopout), 32'd1);
      chk("bp_held_pushout", 32'(pushout), 32'd0);
      stopin = 1'b0;
      @(posedge clk);
      #1;
      chk("bp_b2b_first", 32'(pushout), 32'd1);
      chk("bp_stopout_fall", 32'(stopout), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_b2b_second", 32'(pushout), 32'd1);
      @(posedge clk);
      #1;
      chk("bp_empty", 32'(pushout), 32'd0);
      drive(1'b0, 4'd0, 15'h0, 1'b1, 0, 32'h0, 32'h0);
      repeat (3) idle_cycle();
      chk("flush_empty_pushout", 32'(pushout), 32'd0);
      wait_drain("drain_bp");

      // Mid-stream reset with a queued word and 20 partial bits
      stopin = 1'b1;
      drive(1'b1, 4'd15, 15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      drive(1'b1, 4'd15, 15'h7FFF, 1'b0, 0, 32'h0, 32'h0);
      drive(1'b1, 4'd2,  15'h0003, 1'b0, 0, 32'h0, 32'h0);
      drive(1'b1, 4'd15, 15'h1234, 1'b0, 0, 32'h0, 32'h0);
      drive(1'b1, 4'd5,  15'h001F, 1'b0, 0, 32'h0, 32'h0);
      rst = 1'b1; stopin = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      chk("midrst_pushout", 32'(pushout), 32'd0);
      chk("midrst_dataout", dataout, 32'd0);
      chk("midrst_stopout", 32'(stopout), 32'd0);
      repeat (3) idle_cycle();
      for (int i = 1; i <= 8; i++)
         drive(1'b1, 4'd4, 15'(i), 1'b0, (i == 8) ? 1 : 0, 32'h87654321, 32'h0);
      drive(1'b0, 4'd0, 15'h0, 1'b1, 0, 32'h0, 32'h0);
      wait_drain("drain_after_reset");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
